// File: rtl/present_round_ctrl.sv
// present_round_ctrl
//   Control FSM that sequences a PRESENT-80 encryption datapath. It holds no
//   cipher data. It issues the load, round and final-key strobes and the round
//   index that the datapath and key schedule consume. It also handles the
//   valid/ready handshakes on the plaintext and ciphertext sides.
//
//   Parameters
//     NUM_ROUNDS  full rounds before the final key XOR (legal range 1..31)
//     CNT_W       round counter width, 2**CNT_W > NUM_ROUNDS
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   asynchronous active-low reset
//     in_valid   in   plaintext+key valid at datapath inputs
//     in_ready   out  controller can accept a new block (IDLE)
//     abort      in   synchronous abort, returns to IDLE
//     load_en    out  load plaintext/key registers
//     round_en   out  advance state and key registers by one round
//     round_cnt  out  current round index for the key-schedule counter XOR
//     final_en   out  capture state ^ last round key into the output register
//     out_valid  out  ciphertext valid in the output register
//     out_ready  in   consumer accepts ciphertext
//     busy       out  FSM not in IDLE
module present_round_ctrl #(
  parameter int NUM_ROUNDS = 31,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic             load_en,
  output logic             round_en,
  output logic [CNT_W-1:0] round_cnt,
  output logic             final_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_ROUNDS);

  state_t           state_r;
  logic [CNT_W-1:0] round_cnt_r;
  logic             out_valid_r;

  // Sequencer: state, round counter and the held out_valid flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      round_cnt_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else if (abort) begin
      // Abort outranks every other transition, including an accept in IDLE.
      state_r     <= IDLE;
      round_cnt_r <= CNT_ZERO;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            state_r     <= ROUND;
            round_cnt_r <= CNT_ONE;
          end else begin
            state_r     <= IDLE;
          end
        end
        ROUND: begin
          // The counter saturates at the last round and never wraps.
          if (round_cnt_r < CNT_LAST) begin
            round_cnt_r <= round_cnt_r + CNT_ONE;
          end else begin
            state_r     <= FINAL;
          end
        end
        FINAL: begin
          state_r     <= DONE;
          out_valid_r <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            round_cnt_r <= CNT_ZERO;
            out_valid_r <= 1'b0;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          state_r     <= IDLE;
          round_cnt_r <= CNT_ZERO;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  // Strobe decode from the current state. Abort blanks every strobe in its
  // cycle so the datapath is never disturbed by an aborted step.
  always_comb begin
    load_en  = 1'b0;
    round_en = 1'b0;
    final_en = 1'b0;
    if (abort) begin
      load_en  = 1'b0;
      round_en = 1'b0;
      final_en = 1'b0;
    end else begin
      case (state_r)
        IDLE:    load_en  = in_valid;
        ROUND:   round_en = 1'b1;
        FINAL:   final_en = 1'b1;
        DONE:    load_en  = 1'b0;
        default: load_en  = 1'b0;
      endcase
    end
  end

  // Handshake and status decode. Accepts happen only in IDLE, so no new block
  // can be taken in the same cycle as an output transfer.
  always_comb begin
    in_ready = (state_r == IDLE);
    busy     = (state_r != IDLE);
  end

  assign round_cnt = round_cnt_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_present_round_ctrl.sv
module tb_present_round_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        abort;
  logic        load_en;
  logic        round_en;
  logic [4:0]  round_cnt;
  logic        final_en;
  logic        out_valid;
  logic        out_ready;
  logic        busy;

  int          vectors;
  int          miscompares;
  logic [63:0] exp_q[$];
  logic [63:0] exp_ct;

  // Datapath driven by the controller's strobes
  logic [63:0] pt;
  logic [79:0] key;
  logic [63:0] st;
  logic [79:0] ky;
  logic [63:0] ct;

  localparam logic [63:0] CT_ZERO = 64'h5579C1387B228445;
  localparam logic [63:0] CT_ONES = 64'h3333DCD3213210D2;

  present_round_ctrl #(.NUM_ROUNDS(31), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .abort     (abort),
    .load_en   (load_en),
    .round_en  (round_en),
    .round_cnt (round_cnt),
    .final_en  (final_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] sbox(input logic [3:0] x);
    case (x)
      4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
      4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
      4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
      4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; 4'hF: sbox = 4'h2;
      default: sbox = 4'h0;
    endcase
  endfunction

  function automatic logic [63:0] round_fn(input logic [63:0] s, input logic [79:0] k);
    logic [63:0] x;
    logic [63:0] y;
    x = s ^ k[79:16];
    for (int n = 0; n < 16; n++) x[4*n +: 4] = sbox(x[4*n +: 4]);
    y = 64'd0;
    for (int b = 0; b < 64; b++) y[(b == 63) ? 63 : ((b * 16) % 63)] = x[b];
    return y;
  endfunction

  function automatic logic [79:0] key_upd(input logic [79:0] k, input logic [4:0] c);
    logic [79:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ c;
    return r;
  endfunction

  always @(posedge clk) begin
    if (load_en) begin
      st <= pt;
      ky <= key;
    end else if (round_en) begin
      st <= round_fn(st, ky);
      ky <= key_upd(ky, round_cnt);
    end else if (final_en) begin
      ct <= st ^ ky[79:16];
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached, required run to finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_cnt(input logic [4:0] target, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (round_en === 1'b1 && round_cnt === target) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic wait_out(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    pt = 64'd0; key = 80'd0;
    #3;
    vectors++;
    if ({in_ready, busy, load_en, round_en, final_en, out_valid, round_cnt} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b busy=%b ld=%b rd=%b fin=%b ov=%b cnt=%0d, required 1 0 0 0 0 0 0",
               in_ready, busy, load_en, round_en, final_en, out_valid, round_cnt);
    end
    @(negedge clk); rst_n = 1'b1; #1;
    @(negedge clk); #1;
    vectors++;
    if ({in_ready, busy, out_valid, round_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_release: got rdy=%b busy=%b ov=%b cnt=%0d, required 1 0 0 0",
               in_ready, busy, out_valid, round_cnt);
    end
  endtask

  task automatic test_single_block;
    @(negedge clk);
    pt = 64'd0; key = 80'd0; in_valid = 1'b1; out_ready = 1'b1; #1;
    vectors++;
    if ({load_en, in_ready, round_en, final_en} !== 4'b1100) begin
      miscompares++;
      $display("FAIL single_load: got ld/rdy/rd/fin=%b%b%b%b, required 1100",
               load_en, in_ready, round_en, final_en);
    end
    exp_q.push_back(CT_ZERO);
    @(negedge clk); in_valid = 1'b0; #1;
    for (int i = 1; i <= 31; i++) begin
      vectors++;
      if ({load_en, round_en, final_en, out_valid, in_ready, round_cnt} !==
          {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'(i)}) begin
        miscompares++;
        $display("FAIL single_round%0d: got ld/rd/fin/ov/rdy=%b%b%b%b%b cnt=%0d, required 01000 cnt=%0d",
                 i, load_en, round_en, final_en, out_valid, in_ready, round_cnt, i);
      end
      @(negedge clk); #1;
    end
    vectors++;
    if ({load_en, round_en, final_en, out_valid} !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_final: got ld/rd/fin/ov=%b%b%b%b, required 0010",
               load_en, round_en, final_en, out_valid);
    end
    @(negedge clk); #1;
    vectors++;
    if ({load_en, round_en, final_en, out_valid, busy} !== 5'b00011) begin
      miscompares++;
      $display("FAIL single_done: got ld/rd/fin/ov/busy=%b%b%b%b%b, required 00011",
               load_en, round_en, final_en, out_valid, busy);
    end
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL single_ct: got output with empty scoreboard, required a pending block");
    end else begin
      exp_ct = exp_q.pop_front();
      if (ct !== exp_ct) begin
        miscompares++;
        $display("FAIL single_ct: got %h, required %h", ct, exp_ct);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if ({out_valid, in_ready, busy, round_cnt} !== {1'b0, 1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL single_idle: got ov=%b rdy=%b busy=%b cnt=%0d, required 0 1 0 0",
               out_valid, in_ready, busy, round_cnt);
    end
  endtask

  task automatic test_backpressure;
    bit ok;
    @(negedge clk);
    pt = {64{1'b1}}; key = {80{1'b1}}; in_valid = 1'b1; out_ready = 1'b0; #1;
    vectors++;
    if (load_en !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_load: got ld=%b, required 1", load_en);
    end
    exp_q.push_back(CT_ONES);
    @(negedge clk); in_valid = 1'b0; #1;
    wait_out(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL bp_wait_out: got no out_valid within budget, required out_valid");
    end
    for (int k = 0; k < 10; k++) begin
      vectors++;
      if ({out_valid, load_en, round_en, final_en, busy, in_ready} !== 6'b100010) begin
        miscompares++;
        $display("FAIL bp_hold%0d: got ov/ld/rd/fin/busy/rdy=%b%b%b%b%b%b, required 100010",
                 k, out_valid, load_en, round_en, final_en, busy, in_ready);
      end
      @(negedge clk); #1;
    end
    out_ready = 1'b1; #1;
    vectors++;
    if (exp_q.size() == 0 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_ct: got ov=%b queue=%0d, required ov=1 and a pending block",
               out_valid, exp_q.size());
    end else begin
      exp_ct = exp_q.pop_front();
      if (ct !== exp_ct) begin
        miscompares++;
        $display("FAIL bp_ct: got %h, required %h", ct, exp_ct);
      end
    end
    @(negedge clk); out_ready = 1'b0; #1;
    vectors++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      miscompares++;
      $display("FAIL bp_idle: got rdy/ov/busy=%b%b%b, required 100", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_abort;
    bit ok;
    bit bad;
    @(negedge clk);
    pt = 64'd0; key = 80'd0; in_valid = 1'b1; out_ready = 1'b1; #1;
    @(negedge clk); in_valid = 1'b0; #1;
    wait_cnt(5'd15, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL abort_reach15: got no round 15 within budget, required round_cnt=15");
    end
    abort = 1'b1; #1;
    vectors++;
    if ({load_en, round_en, final_en} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_strobes: got ld/rd/fin=%b%b%b, required 000", load_en, round_en, final_en);
    end
    @(negedge clk); abort = 1'b0; #1;
    vectors++;
    if ({in_ready, busy, out_valid, round_cnt} !== {1'b1, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL abort_idle: got rdy=%b busy=%b ov=%b cnt=%0d, required 1 0 0 0",
               in_ready, busy, out_valid, round_cnt);
    end
    bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (final_en !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
      @(negedge clk); #1;
    end
    vectors++;
    if (bad) begin
      miscompares++;
      $display("FAIL abort_quiet: got final_en/out_valid/busy after abort, required none");
    end
    in_valid = 1'b1; abort = 1'b1; #1;
    vectors++;
    if (load_en !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_load: got ld=%b, required 0", load_en);
    end
    @(negedge clk); in_valid = 1'b0; abort = 1'b0; #1;
    vectors++;
    if ({busy, round_cnt, load_en} !== {1'b0, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL abort_noaccept: got busy=%b cnt=%0d ld=%b, required 0 0 0",
               busy, round_cnt, load_en);
    end
  endtask

  task automatic test_reset_mid_round;
    bit ok;
    @(negedge clk);
    pt = 64'd0; key = 80'd0; in_valid = 1'b1; out_ready = 1'b1; #1;
    @(negedge clk); in_valid = 1'b0; #1;
    wait_cnt(5'd7, ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL rst_reach7: got no round 7 within budget, required round_cnt=7");
    end
    rst_n = 1'b0; #1;
    vectors++;
    if ({round_cnt, out_valid, in_ready, busy, round_en} !== {5'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_async: got cnt=%0d ov=%b rdy=%b busy=%b rd=%b, required 0 0 1 0 0",
               round_cnt, out_valid, in_ready, busy, round_en);
    end
    @(negedge clk); rst_n = 1'b1; #1;
  endtask

  task automatic test_back_to_back;
    int loads[$];
    int busy_bad;
    bit ok;
    busy_bad = 0;
    @(negedge clk);
    pt = 64'd0; key = 80'd0; in_valid = 1'b1; out_ready = 1'b1; #1;
    for (int c = 0; c < 110; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL b2b_ct: got output at cycle %0d with empty scoreboard, required none", c);
        end else begin
          exp_ct = exp_q.pop_front();
          if (ct !== exp_ct) begin
            miscompares++;
            $display("FAIL b2b_ct: got %h, required %h", ct, exp_ct);
          end
        end
      end
      if (load_en === 1'b1) begin
        loads.push_back(c);
        exp_q.push_back(CT_ZERO);
      end else if (loads.size() > 0 && busy !== 1'b1) begin
        busy_bad++;
      end
      @(negedge clk); #1;
    end
    in_valid = 1'b0;
    wait_out(ok);
    vectors++;
    if (!ok || exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL b2b_drain: got ov=%b queue=%0d, required ov=1 and a pending block",
               out_valid, exp_q.size());
    end else begin
      exp_ct = exp_q.pop_front();
      if (ct !== exp_ct) begin
        miscompares++;
        $display("FAIL b2b_drain_ct: got %h, required %h", ct, exp_ct);
      end
    end
    @(negedge clk); #1;
    vectors++;
    if (loads.size() !== 4) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d load pulses, required 4", loads.size());
    end
    for (int j = 1; j < loads.size(); j++) begin
      vectors++;
      if (loads[j] - loads[j-1] !== 34) begin
        miscompares++;
        $display("FAIL b2b_gap%0d: got %0d cycles, required 34", j, loads[j] - loads[j-1]);
      end
    end
    vectors++;
    if (busy_bad !== 0) begin
      miscompares++;
      $display("FAIL b2b_busy: got %0d idle cycles between loads, required 0", busy_bad);
    end
    vectors++;
    if (exp_q.size() !== 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: got queue=%0d busy=%b, required 0 0", exp_q.size(), busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_abort();
    test_reset_mid_round();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
